// File: rtl/instr_encoder.sv
// instr_encoder: assembles raw RV64IM instruction words from a decoded
// control record. S1 registers the request, S2 encodes combinationally and
// writes an output FIFO on the following edge. Unencodable records produce
// a NOP (0x00000013) tagged with out_err.
// Optional feature: define ENC_ERRCNT_EN to add the saturating err_count port.

package pipes;
    typedef enum logic [4:0] {
        UNKNOWN, ALUI, ALU, ALUIW, ALUW, LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU, LD, SD, CSR, CSRI
    } op_t;

    typedef enum logic [4:0] {
        NOTALU, ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        MULT, DIV, DIVU, REM, REMU, COMPARE, SMALL, SMALLU,
        CSRRW, CSRRS, CSRRC
    } alufunc_t;
endpackage

module instr_encoder
    import pipes::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              in_op,
    input  alufunc_t         in_alufunc,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [63:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err
`ifdef ENC_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] err_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Bad sizing is caught at elaboration rather than producing a broken FIFO.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_check
        $error("instr_encoder: FIFO_DEPTH must be a power of two >= 2 and CNT_W >= 1");
    end

    // ---------------- helpers ----------------
    function automatic logic fits_s(input logic [63:0] v, input int n);
        logic [63:0] t;
        t = $signed(v) >>> (n - 1);
        return (t == '0) || (t == '1);
    endfunction

    function automatic logic [2:0] alu_f3(input alufunc_t f);
        case (f)
            SLL:              return 3'b001;
            SLT:              return 3'b010;
            SLTU:             return 3'b011;
            XOR, DIV:         return 3'b100;
            SRL, SRA, DIVU:   return 3'b101;
            OR, REM:          return 3'b110;
            AND, REMU:        return 3'b111;
            default:          return 3'b000;   // ADD, SUB, MULT
        endcase
    endfunction

    function automatic logic is_m(input alufunc_t f);
        return f inside {MULT, DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic is_alu(input alufunc_t f);
        return f inside {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
                         MULT, DIV, DIVU, REM, REMU};
    endfunction

    // ---------------- S1 ----------------
    logic        s1_valid;
    op_t         s1_op;
    alufunc_t    s1_func;
    logic [4:0]  s1_rd, s1_rs1, s1_rs2;
    logic [63:0] s1_imm;
    logic [AW:0] count;
    logic        accept;

    assign in_ready = ({1'b0, count} + {{(AW+1){1'b0}}, s1_valid}) < (AW+2)'(FIFO_DEPTH);
    assign accept   = in_valid & in_ready;

    // S1 valid: every S1 entry drains into the FIFO on the next edge.
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) s1_valid <= 1'b0;
        else         s1_valid <= accept;

    // S1 payload: captured on accept, no reset needed.
    always_ff @(posedge clk)
        if (accept) begin
            s1_op   <= in_op;
            s1_func <= in_alufunc;
            s1_rd   <= in_rd;
            s1_rs1  <= in_rs1;
            s1_rs2  <= in_rs2;
            s1_imm  <= in_imm;
        end

    // ---------------- S2 encode ----------------
    logic [31:0] raw, enc_instr;
    logic        bad, enc_err;
    logic [2:0]  f3;
    logic [6:0]  f7;

    // Field assembly and legality check for the record held in S1.
    always_comb begin
        raw = NOP;
        bad = 1'b0;
        f3  = alu_f3(s1_func);
        f7  = (s1_func == SUB || s1_func == SRA) ? 7'b0100000 :
              is_m(s1_func) ? 7'b0000001 : 7'b0000000;
        case (s1_op)
            ALUI:
                if (s1_func inside {SLL, SRL, SRA}) begin
                    bad = |s1_imm[63:6];
                    raw = {(s1_func == SRA) ? 6'b010000 : 6'b000000, s1_imm[5:0],
                           s1_rs1, f3, s1_rd, 7'b0010011};
                end else begin
                    bad = !fits_s(s1_imm, 12) || !is_alu(s1_func) || s1_func == SUB || is_m(s1_func);
                    raw = {s1_imm[11:0], s1_rs1, f3, s1_rd, 7'b0010011};
                end
            ALUIW:
                if (s1_func inside {SLL, SRL, SRA}) begin
                    bad = |s1_imm[63:5];
                    raw = {(s1_func == SRA) ? 7'b0100000 : 7'b0000000, s1_imm[4:0],
                           s1_rs1, f3, s1_rd, 7'b0011011};
                end else begin
                    bad = !fits_s(s1_imm, 12) || s1_func != ADD;
                    raw = {s1_imm[11:0], s1_rs1, f3, s1_rd, 7'b0011011};
                end
            ALU: begin
                bad = !is_alu(s1_func);
                raw = {f7, s1_rs2, s1_rs1, f3, s1_rd, 7'b0110011};
            end
            ALUW: begin
                bad = !(s1_func inside {ADD, SUB, SLL, SRL, SRA, MULT, DIV, DIVU, REM, REMU});
                raw = {f7, s1_rs2, s1_rs1, f3, s1_rd, 7'b0111011};
            end
            LUI, AUIPC: begin
                bad = (s1_imm[11:0] != 12'h000) || !fits_s(s1_imm, 32);
                raw = {s1_imm[31:12], s1_rd, (s1_op == LUI) ? 7'b0110111 : 7'b0010111};
            end
            JAL: begin
                bad = !fits_s(s1_imm, 21) || s1_imm[0];
                raw = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, 7'b1101111};
            end
            JALR: begin
                bad = !fits_s(s1_imm, 12);
                raw = {s1_imm[11:0], s1_rs1, 3'b000, s1_rd, 7'b1100111};
            end
            BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
                case (s1_op)
                    BEQ:     begin f3 = 3'b000; bad = s1_func != COMPARE; end
                    BNE:     begin f3 = 3'b001; bad = s1_func != COMPARE; end
                    BLT:     begin f3 = 3'b100; bad = s1_func != SMALL;   end
                    BGE:     begin f3 = 3'b101; bad = s1_func != SMALL;   end
                    BLTU:    begin f3 = 3'b110; bad = s1_func != SMALLU;  end
                    default: begin f3 = 3'b111; bad = s1_func != SMALLU;  end
                endcase
                bad = bad || !fits_s(s1_imm, 13) || s1_imm[0];
                raw = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, f3,
                       s1_imm[4:1], s1_imm[11], 7'b1100011};
            end
            LD: begin
                bad = !fits_s(s1_imm, 12);
                raw = {s1_imm[11:0], s1_rs1, 3'b011, s1_rd, 7'b0000011};
            end
            SD: begin
                bad = !fits_s(s1_imm, 12);
                raw = {s1_imm[11:5], s1_rs2, s1_rs1, 3'b011, s1_imm[4:0], 7'b0100011};
            end
            CSR, CSRI: begin
                case (s1_func)
                    CSRRW:   f3 = 3'b001;
                    CSRRS:   f3 = 3'b010;
                    CSRRC:   f3 = 3'b011;
                    default: begin f3 = 3'b000; bad = 1'b1; end
                endcase
                if (s1_op == CSRI) f3[2] = 1'b1;
                // For CSRI the rs1 slot carries the 5-bit zimm.
                raw = {s1_imm[11:0], s1_rs1, f3, s1_rd, 7'b1110011};
            end
            default: bad = 1'b1;
        endcase
        enc_err   = bad;
        enc_instr = bad ? NOP : raw;
    end

    // ---------------- output FIFO ----------------
    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    assign push = s1_valid;
    assign pop  = out_valid & out_ready;

    // FIFO storage: {err, instr}; contents are qualified by count.
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {enc_err, enc_instr};

    // Pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end

    assign out_valid = (count != '0);
    assign out_instr = out_valid ? mem[rd_ptr][31:0] : 32'h0;
    assign out_err   = out_valid & mem[rd_ptr][32];

`ifdef ENC_ERRCNT_EN
    // Saturating count of error words written into the FIFO.
    always_ff @(posedge clk or negedge resetn)
        if (!resetn)
            err_count <= '0;
        else if (push && enc_err && !(&err_count))
            err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are queued when a
// request is accepted and compared when the FIFO head is popped.
module tb_instr_encoder;
    import pipes::*;

    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    op_t         in_op = UNKNOWN;
    alufunc_t    in_alufunc = NOTALU;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [63:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic        out_err;
`ifdef ENC_ERRCNT_EN
    logic [CNT_W-1:0] err_count;
`endif

    instr_encoder #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_alufunc(in_alufunc),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err)
`ifdef ENC_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0, failures = 0;
    int   n_err = 0, n_push = 0, n_pop = 0, cyc = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Pop side: compare the head against the oldest queued expectation.
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                mon_e = sb.pop_front();
                chk("instr", 64'(out_instr), 64'(mon_e.instr));
                chk("err", 64'(out_err), 64'(mon_e.err));
                n_pop++;
            end
        end
    end

    // Hold the request until accepted; returns #1 after the accepting edge.
    task automatic push(input op_t op, input alufunc_t f, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [63:0] imm, input logic [31:0] ei, input logic ee);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1; in_op = op; in_alufunc = f;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
        end
        #1;
        if (acc) begin
            sb.push_back({ei, ee});
            n_push++;
            if (ee) n_err++;
        end else begin
            chk("push_timeout", 64'(acc), 64'd1);
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    int c0;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_out_err",   64'(out_err),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
`ifdef ENC_ERRCNT_EN
        chk("rst_err_count", 64'(err_count), 64'd0);
`endif
        resetn = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Latency: out_valid two cycles after the accepting cycle
        push(ALUI, ADD, 5'd1, 5'd0, 5'd0, 64'd5, 32'h00500093, 1'b0);
        in_valid = 1'b0;
        chk("lat_edge1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_edge2", 64'(out_valid), 64'd1);
        drain("drain_lat");

        // First error word: err_count 0 -> 1
        push(ALUI, ADD, 5'd1, 5'd0, 5'd0, 64'd2048, 32'h00000013, 1'b1);
        in_valid = 1'b0;
        drain("drain_err1");
`ifdef ENC_ERRCNT_EN
        chk("err_count_1", 64'(err_count), 64'd1);
`endif

        // Back-to-back mix of formats and legality failures
        c0 = cyc;
        push(ALU,   SUB,     5'd3, 5'd1, 5'd2, 64'd0,        32'h402081B3, 1'b0);
        push(BEQ,   COMPARE, 5'd0, 5'd1, 5'd2, 64'd8,        32'h00208463, 1'b0);
        push(LD,    ADD,     5'd5, 5'd2, 5'd0, 64'd16,       32'h01013283, 1'b0);
        push(ALUI,  SRA,     5'd1, 5'd1, 5'd0, 64'd63,       32'h43F0D093, 1'b0);
        push(BEQ,   COMPARE, 5'd0, 5'd1, 5'd2, 64'd3,        32'h00000013, 1'b1);
        push(LUI,   ADD,     5'd2, 5'd0, 5'd0, 64'h12345000, 32'h12345137, 1'b0);
        push(JAL,   ADD,     5'd1, 5'd0, 5'd0, 64'd2048,     32'h001000EF, 1'b0);
        push(SD,    ADD,     5'd0, 5'd2, 5'd5, 64'd8,        32'h00513423, 1'b0);
        push(ALUW,  MULT,    5'd3, 5'd1, 5'd2, 64'd0,        32'h022081BB, 1'b0);
        push(CSRI,  CSRRS,   5'd1, 5'd5, 5'd0, 64'h300,      32'h3002E0F3, 1'b0);
        push(ALUIW, SRA,     5'd1, 5'd1, 5'd0, 64'd31,       32'h41F0D09B, 1'b0);
        push(ALUIW, SLL,     5'd1, 5'd1, 5'd0, 64'd32,       32'h00000013, 1'b1);
        push(ALUI,  SUB,     5'd1, 5'd1, 5'd0, 64'd1,        32'h00000013, 1'b1);
        push(UNKNOWN, ADD,   5'd1, 5'd1, 5'd0, 64'd0,        32'h00000013, 1'b1);
        push(LUI,   ADD,     5'd2, 5'd0, 5'd0, 64'h123,      32'h00000013, 1'b1);
        push(ALUI,  ADD,     5'd1, 5'd0, 5'd0, '1,           32'hFFF00093, 1'b0);
        push(BLT,   COMPARE, 5'd0, 5'd1, 5'd2, 64'd8,        32'h00000013, 1'b1);
        in_valid = 1'b0;
        chk("throughput", 64'(cyc - c0), 64'd17);
        drain("drain_mix");
`ifdef ENC_ERRCNT_EN
        chk("err_count_mix", 64'(err_count), 64'(n_err));
`endif

        // Backpressure: fill the FIFO, then release
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(ALU, ADD, 5'(i), 5'd1, 5'd2, 64'd0, 32'h00208033 | (32'(i) << 7), 1'b0);
            chk("bp_in_ready", 64'(in_ready), (i < 4) ? 64'd1 : 64'd0);
        end
        fork
            begin
                push(ALU, ADD, 5'd5, 5'd1, 5'd2, 64'd0, 32'h002082B3, 1'b0);
                push(ALU, ADD, 5'd6, 5'd1, 5'd2, 64'd0, 32'h00208333, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                chk("bp_hold_ready", 64'(in_ready), 64'd0);
                chk("bp_hold_queued", 64'(sb.size()), 64'd4);
                out_ready = 1'b1;
            end
        join
        drain("drain_bp");

        // Reset with three entries queued
        out_ready = 1'b0;
        push(LD, ADD, 5'd1, 5'd2, 5'd0, 64'd8,  32'h00813083, 1'b0);
        push(LD, ADD, 5'd2, 5'd2, 5'd0, 64'd16, 32'h01013103, 1'b0);
        push(LD, ADD, 5'd3, 5'd2, 5'd0, 64'd24, 32'h01813183, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #1;
        resetn = 1'b0;
        n_push -= sb.size();
        sb.delete();
        n_err = 0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_instr", 64'(out_instr), 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        chk("rst_rel_ready", 64'(in_ready), 64'd1);
`ifdef ENC_ERRCNT_EN
        chk("rst_err_count", 64'(err_count), 64'd0);
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        push(SD, ADD, 5'd0, 5'd2, 5'd5, 64'd8, 32'h00513423, 1'b0);
        in_valid = 1'b0;
        drain("drain_post_rst");
        chk("pop_count", 64'(n_pop), 64'(n_push));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
